csa_accumulator: RTL

Parametrised, sequential multi-operand adder that reduces a stream of WIDTH-bit operands into a redundant sum/carry pair, one 3:2 reduction per accepted beat. After the last operand it resolves the redundant pair with a chunked carry-propagate adder. The result is presented on a valid/ready output port. It sits in the MiniSRC datapath as the generalised successor of the fixed 32-bit 3:2 reducer, and is used by the multiplier (partial-product accumulation) and by multi-operand address arithmetic.

---
 rtl/csa_pkg.sv | 17 +
 rtl/reducer3_2_p.sv | 15 +
 rtl/csa_accumulator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save multi-operand accumulator.
package csa_pkg;

  localparam int unsigned CountW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StResolve,
    StDone
  } csa_state_e;

  function automatic int unsigned nchunks(int unsigned acc_w, int unsigned chunk);
    return (acc_w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/reducer3_2_p.sv
// Combinational W-bit 3:2 carry-save cell: bitwise sum and majority carry.
module reducer3_2_p #(
  parameter int unsigned W = 36
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] cy_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign cy_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_accumulator.sv
// Sequential multi-operand adder: 3:2 accumulation per beat, then chunked CPA resolve.
// Define CSA_SIGNED_EN to sign-extend operands (two's-complement result).
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GUARD = 4,
  parameter int unsigned CHUNK = 16
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+GUARD-1:0]   out_sum,
  output logic [CountW-1:0]        out_count
);

  localparam int unsigned AccW      = WIDTH + GUARD;
  localparam int unsigned NChunks   = nchunks(AccW, CHUNK);
  localparam int unsigned ChunkIdxW = (NChunks > 1) ? $clog2(NChunks) : 1;

  csa_state_e            state_q, state_d;
  logic [AccW-1:0]       sum_q, sum_d;
  logic [AccW-1:0]       carry_q, carry_d;
  logic [CountW-1:0]     count_q, count_d;
  logic [ChunkIdxW-1:0]  chunk_q, chunk_d;
  logic                  cpa_c_q, cpa_c_d;
  logic [AccW-1:0]       out_sum_q, out_sum_d;

  logic [AccW-1:0]       x;
  logic [AccW-1:0]       c2;
  logic [AccW-1:0]       red_s, red_cy;
  logic [CHUNK-1:0]      a_chunk, b_chunk;
  logic [CHUNK:0]        chunk_res;
  logic [31:0]           base;
  logic                  accept;

`ifdef CSA_SIGNED_EN
  assign x = {{GUARD{in_data[WIDTH-1]}}, in_data};
`else
  assign x = {{GUARD{1'b0}}, in_data};
`endif

  assign c2 = {carry_q[AccW-2:0], 1'b0};

  reducer3_2_p #(
    .W (AccW)
  ) u_reducer (
    .a_i  (sum_q),
    .b_i  (c2),
    .c_i  (x),
    .s_o  (red_s),
    .cy_o (red_cy)
  );

  assign in_ready  = (state_q == StIdle) || (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_sum_q;
  assign out_count = count_q;
  assign accept    = in_valid && in_ready;

  // Pick out the current chunk; bits past the top of the accumulator read as zero.
  assign base = 32'(chunk_q) * CHUNK;
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      if (base + j < AccW) begin
        a_chunk[j] = sum_q[base + j];
        b_chunk[j] = c2[base + j];
      end
    end
  end

  assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(cpa_c_q);

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    count_d   = count_q;
    chunk_d   = chunk_q;
    cpa_c_d   = cpa_c_q;
    out_sum_d = out_sum_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sum_d   = x;
          carry_d = '0;
          count_d = CountW'(1);
          chunk_d = '0;
          cpa_c_d = 1'b0;
          state_d = in_last ? StResolve : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          sum_d   = red_s;
          carry_d = red_cy;
          if (count_q != {CountW{1'b1}}) count_d = count_q + CountW'(1);
          if (in_last) state_d = StResolve;
        end
      end
      StResolve: begin
        for (int unsigned i = 0; i < AccW; i++) begin
          if ((i / CHUNK) == 32'(chunk_q)) out_sum_d[i] = chunk_res[i % CHUNK];
        end
        cpa_c_d = chunk_res[CHUNK];
        chunk_d = chunk_q + ChunkIdxW'(1);
        if (chunk_q == ChunkIdxW'(NChunks - 1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q   <= StIdle;
      sum_q     <= '0;
      carry_q   <= '0;
      count_q   <= '0;
      chunk_q   <= '0;
      cpa_c_q   <= 1'b0;
      out_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      chunk_q   <= chunk_d;
      cpa_c_q   <= cpa_c_d;
      out_sum_q <= out_sum_d;
    end
  end

endmodule
